// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses ASCII L/N/V commands into LED, note and volume regs.
// Define UART_CMD_LOWERCASE_EN to also accept lowercase commands and hex digits.
module uart_cmd_ctrl #(
    parameter int NUM_LEDS       = 4,
    parameter int NOTE_DIGITS    = 2,
    parameter int VOL_WDTH       = 4,
    parameter int TIMEOUT_CYCLES = 24576000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     tx_ready,
    output logic                     tx_send,
    output logic [7:0]               tx_byte,
    output logic [NUM_LEDS-1:0]      led,
    output logic [4*NOTE_DIGITS-1:0] note,
    output logic                     change_note,
    output logic [VOL_WDTH-1:0]      volume,
    output logic                     resp_drop
);
    localparam int NW = 4 * NOTE_DIGITS;
    localparam int CW = $clog2(NOTE_DIGITS) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0]    LED_MAX  = 4'(NUM_LEDS);
    localparam logic [3:0]    VOL_MAX  = 4'((1 << VOL_WDTH) - 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(NOTE_DIGITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    ACK_K    = 8'h4B;
    localparam logic [7:0]    ACK_E    = 8'h45;

    typedef enum logic {IDLE, ARG} state_t;
    typedef enum logic [1:0] {CMD_L, CMD_N, CMD_V} cmd_t;

    state_t        state;
    cmd_t          cmd;
    cmd_t          byte_cmd;
    logic [CW-1:0] cnt;
    logic [NW-1:0] shadow;
    logic [TW-1:0] timer;

    logic                is_cmd;
    logic                dig_ok;
    logic [3:0]          dig_val;
    logic                arg_ok;
    logic                is_final;
    logic [NUM_LEDS-1:0] led_hot;
    logic [NW-1:0]       note_next;
    logic                resp_req;
    logic [7:0]          resp_byte;

    // Decode the incoming byte as a command letter and as a hex digit.
    always_comb begin
        is_cmd   = 1'b1;
        byte_cmd = CMD_L;
        case (rx_byte)
            "L": byte_cmd = CMD_L;
            "N": byte_cmd = CMD_N;
            "V": byte_cmd = CMD_V;
`ifdef UART_CMD_LOWERCASE_EN
            "l": byte_cmd = CMD_L;
            "n": byte_cmd = CMD_N;
            "v": byte_cmd = CMD_V;
`endif
            default: is_cmd = 1'b0;
        endcase
        dig_ok  = 1'b1;
        dig_val = 4'd0;
        if (rx_byte >= "0" && rx_byte <= "9")
            dig_val = rx_byte[3:0];
        else if (rx_byte >= "A" && rx_byte <= "F")
            dig_val = rx_byte[3:0] + 4'd9;
`ifdef UART_CMD_LOWERCASE_EN
        else if (rx_byte >= "a" && rx_byte <= "f")
            dig_val = rx_byte[3:0] + 4'd9;
`endif
        else
            dig_ok = 1'b0;
    end

    // Range-check the digit for the latched command and build commit values.
    always_comb begin
        case (cmd)
            CMD_L:   arg_ok = dig_ok && (dig_val <= LED_MAX);
            CMD_V:   arg_ok = dig_ok && (dig_val <= VOL_MAX);
            default: arg_ok = dig_ok;
        endcase
        is_final = (cmd != CMD_N) || (cnt == LAST_DIG);
        led_hot  = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            led_hot[i] = (dig_val == 4'(i + 1));
        note_next = (shadow << 4) | NW'(dig_val);
    end

    // Select the acknowledgement, if any, produced this cycle.
    always_comb begin
        resp_req  = 1'b0;
        resp_byte = 8'h00;
        if (state == IDLE) begin
            if (rx_valid && !is_cmd && rx_byte != 8'h0D && rx_byte != 8'h0A) begin
                resp_req  = 1'b1;
                resp_byte = ACK_E;
            end
        end else if (rx_valid) begin
            if (!arg_ok) begin
                resp_req  = 1'b1;
                resp_byte = ACK_E;
            end else if (is_final) begin
                resp_req  = 1'b1;
                resp_byte = ACK_K;
            end
        end else if (timer == TMO_LAST) begin
            resp_req  = 1'b1;
            resp_byte = ACK_E;
        end
    end

    // Command FSM, target registers and the one-deep response buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= CMD_L;
            cnt         <= '0;
            shadow      <= '0;
            timer       <= '0;
            led         <= '0;
            note        <= '0;
            change_note <= 1'b0;
            volume      <= '0;
            tx_send     <= 1'b0;
            tx_byte     <= 8'h00;
            resp_drop   <= 1'b0;
        end else begin
            change_note <= 1'b0;
            resp_drop   <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (rx_valid && is_cmd) begin
                        cmd    <= byte_cmd;
                        cnt    <= '0;
                        shadow <= '0;
                        state  <= ARG;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (!arg_ok) begin
                            state <= IDLE;
                        end else if (is_final) begin
                            state <= IDLE;
                            case (cmd)
                                CMD_L: led <= led_hot;
                                CMD_N: begin
                                    note        <= note_next;
                                    change_note <= 1'b1;
                                end
                                default: volume <= dig_val[VOL_WDTH-1:0];
                            endcase
                        end else begin
                            shadow <= note_next;
                            cnt    <= cnt + 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
            // A transfer this cycle frees the slot for a same-cycle response.
            if (resp_req) begin
                if (tx_send && !tx_ready) begin
                    resp_drop <= 1'b1;
                end else begin
                    tx_send <= 1'b1;
                    tx_byte <= resp_byte;
                end
            end else if (tx_send && tx_ready) begin
                tx_send <= 1'b0;
            end
        end
    end
endmodule
